barrel_shifter: RTL and testbench
=================================

// Module: barrel_shifter
// PURPOSE
//   Registered 32-bit barrel shifter: logical left, logical right, arithmetic right, rotate right.
//   Datapath is pure mux-based: log2(WIDTH) cascaded stages; stage k shifts by 2^k when amt[k]=1.
//   No adders, no variable-shift operators in the datapath.
//   Sits in the execute/ALU path; single-cycle latency from a sampled input to the registered result.
// PARAMETERS
//   WIDTH   32  data width; must be a power of two
//   SHW     5   shift-amount width, = log2(WIDTH)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   a          in   WIDTH  operand to shift
//   b          in   SHW    shift amount, 0..WIDTH-1, unsigned
//   c          in   2      op: 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_valid   in   1      a/b/c valid this cycle
//   z          out  WIDTH  registered result
//   out_valid  out  1      z holds a new result
// BEHAVIOUR
//   - Reset: rst_n low asynchronously forces z=0 and out_valid=0, regardless of clk.
//     Both hold while rst_n is low. The first capture occurs on the first rising clk after rst_n rises.
//   - Latency 1: at rising clk with in_valid=1, z <= f(a,b,c) and out_valid <= 1.
//   - in_valid=0 at rising clk: z holds its previous value, out_valid <= 0.
//   - No backpressure; a new operation may be accepted every cycle.
//   - SLL: z = a << b, zero-fill LSBs.
//   - SRL: z = a >> b, zero-fill MSBs.
//   - SRA: z = a >> b, fill MSBs with a[WIDTH-1].
//   - ROR: z = {a, a} >> b, low WIDTH bits; bits leaving the LSB re-enter at the MSB.
//   - b=0: z = a for every op.
//   - b=WIDTH-1 (31): maximum shift. No modulo or overflow case exists, since b cannot exceed WIDTH-1.
//   - Left shift: implement by bit-reversing the operand, right-shifting, then bit-reversing back,
//     or with dedicated left stages; either is acceptable.
//   - Fill bit per stage: 0 for SLL/SRL, a[WIDTH-1] for SRA, wrapped bits for ROR.
//   - Input/output handling is the same for all four op codes.
//   - No X on z after reset for any legal input.
//   - Reset asserted mid-stream: z=0 and out_valid=0 immediately.
//     Pending results are discarded; there is no recovery state.
// TESTING
//   1. Reset: rst_n=0 with a=FFFF_FFFF, b=31, in_valid=1 -> z=0000_0000, out_valid=0;
//      z/out_valid clear asynchronously without any clk edge.
//   2. a=FFFF_FFFF, b=31, in_valid=1, c=SLL,SRL,SRA,ROR on consecutive cycles ->
//      next-cycle z=8000_0000, 0000_0001, FFFF_FFFF, FFFF_FFFF; out_valid=1 each cycle.
//   3. a=1000_0000, b=31, c=SLL,SRL,SRA,ROR on consecutive cycles ->
//      z=0000_0000, 0000_0000, 0000_0000, 2000_0000.
//   4. a=8000_0000, b=4: SRA -> F800_0000, SRL -> 0800_0000.
//      a=1234_5678, b=8: ROR -> 7812_3456, SLL -> 3456_7800.
//   5. b=0 with a=DEAD_BEEF for all four ops -> z=DEAD_BEEF each cycle.
//      Then in_valid=0 -> z holds DEAD_BEEF, out_valid=0.
//   6. Random a/b/c for >=10k cycles with in_valid toggling: compare z against a behavioural
//      shift/rotate reference model, one-cycle delayed.
//      Assert reset mid-run: z=0 immediately, and correct results resume on the first valid cycle.

Source files
------------

// File: rtl/barrel_shifter.sv
// Registered 32-bit barrel shifter (SLL/SRL/SRA/ROR) built from log2(WIDTH) mux stages.
// Left shifts reuse the right-shift network by bit-reversing the operand before and after.
module barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    input  logic [1:0]       c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] z,
    output logic             out_valid
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic                     is_left;
    logic                     is_rot;
    logic                     sign_fill;
    logic [SHW:0][WIDTH-1:0]  stage;
    logic [WIDTH-1:0]         a_rev;
    logic [WIDTH-1:0]         res_rev;
    logic [WIDTH-1:0]         result;

    assign is_left   = (c == OP_SLL);
    assign is_rot    = (c == OP_ROR);
    assign sign_fill = (c == OP_SRA) & a[WIDTH-1];

    // Stage k moves bit i+2^k down to bit i; bits shifted in from above the
    // MSB are either wrapped (rotate) or the fill bit (zero or sign).
    always_comb begin
        a_rev   = '0;
        res_rev = '0;
        stage   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            a_rev[i] = a[WIDTH-1-i];
        end
        stage[0] = is_left ? a_rev : a;
        for (int k = 0; k < SHW; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!b[k]) begin
                    stage[k+1][i] = stage[k][i];
                end else if (i + (1 << k) < WIDTH) begin
                    stage[k+1][i] = stage[k][i + (1 << k)];
                end else if (is_rot) begin
                    stage[k+1][i] = stage[k][i + (1 << k) - WIDTH];
                end else begin
                    stage[k+1][i] = sign_fill;
                end
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            res_rev[i] = stage[SHW][WIDTH-1-i];
        end
        result = is_left ? res_rev : stage[SHW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z <= result;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed corner cases, then randomized
// operations compared against a plain-arithmetic shift/rotate model.
module tb_barrel_shifter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   b;
    logic [1:0]       c;
    logic             in_valid;
    logic [WIDTH-1:0] z;
    logic             out_valid;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_z;
    logic             exp_v;

    barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .in_valid  (in_valid),
        .z         (z),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] op_a,
                                                   input logic [SHW-1:0]   op_b,
                                                   input logic [1:0]       op_c);
        logic [2*WIDTH-1:0] both;
        case (op_c)
            2'b00:   return op_a << op_b;
            2'b01:   return op_a >> op_b;
            2'b10:   return WIDTH'($signed(op_a) >>> op_b);
            default: begin
                both = {op_a, op_a} >> op_b;
                return both[WIDTH-1:0];
            end
        endcase
    endfunction

    // Drive one operation away from the clock edge, then sample just after the capture edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] na, input logic [SHW-1:0] nb,
                                 input logic [1:0] nc, input logic nv);
        @(negedge clk);
        a        = na;
        b        = nb;
        c        = nc;
        in_valid = nv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] want_z,
                               input logic want_v);
        checks++;
        assert (z === want_z) else begin
            failures++;
            $error("[TB] FAIL %s z got=%h expected=%h", tag, z, want_z);
        end
        checks++;
        assert (out_valid === want_v) else begin
            failures++;
            $error("[TB] FAIL %s out_valid got=%b expected=%b", tag, out_valid, want_v);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [SHW-1:0]   rb;
        logic [1:0]       rc;
        logic             rv;

        rst_n    = 1'b0;
        a        = 32'hFFFF_FFFF;
        b        = 5'd31;
        c        = 2'b00;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hold", 32'h0000_0000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] max shift of all-ones");
        applyStimulus(32'hFFFF_FFFF, 5'd31, 2'b00, 1'b1); checkOutput("ones_sll31", 32'h8000_0000, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 5'd31, 2'b01, 1'b1); checkOutput("ones_srl31", 32'h0000_0001, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 5'd31, 2'b10, 1'b1); checkOutput("ones_sra31", 32'hFFFF_FFFF, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 5'd31, 2'b11, 1'b1); checkOutput("ones_ror31", 32'hFFFF_FFFF, 1'b1);

        applyStimulus(32'h1000_0000, 5'd31, 2'b00, 1'b1); checkOutput("b28_sll31", 32'h0000_0000, 1'b1);
        applyStimulus(32'h1000_0000, 5'd31, 2'b01, 1'b1); checkOutput("b28_srl31", 32'h0000_0000, 1'b1);
        applyStimulus(32'h1000_0000, 5'd31, 2'b10, 1'b1); checkOutput("b28_sra31", 32'h0000_0000, 1'b1);
        applyStimulus(32'h1000_0000, 5'd31, 2'b11, 1'b1); checkOutput("b28_ror31", 32'h2000_0000, 1'b1);

        applyStimulus(32'h8000_0000, 5'd4, 2'b10, 1'b1); checkOutput("msb_sra4", 32'hF800_0000, 1'b1);
        applyStimulus(32'h8000_0000, 5'd4, 2'b01, 1'b1); checkOutput("msb_srl4", 32'h0800_0000, 1'b1);
        applyStimulus(32'h1234_5678, 5'd8, 2'b11, 1'b1); checkOutput("pat_ror8", 32'h7812_3456, 1'b1);
        applyStimulus(32'h1234_5678, 5'd8, 2'b00, 1'b1); checkOutput("pat_sll8", 32'h3456_7800, 1'b1);

        $display("[TB] zero shift and hold");
        applyStimulus(32'hDEAD_BEEF, 5'd0, 2'b00, 1'b1); checkOutput("zero_sll", 32'hDEAD_BEEF, 1'b1);
        applyStimulus(32'hDEAD_BEEF, 5'd0, 2'b01, 1'b1); checkOutput("zero_srl", 32'hDEAD_BEEF, 1'b1);
        applyStimulus(32'hDEAD_BEEF, 5'd0, 2'b10, 1'b1); checkOutput("zero_sra", 32'hDEAD_BEEF, 1'b1);
        applyStimulus(32'hDEAD_BEEF, 5'd0, 2'b11, 1'b1); checkOutput("zero_ror", 32'hDEAD_BEEF, 1'b1);
        applyStimulus(32'h0123_4567, 5'd9, 2'b00, 1'b0); checkOutput("hold_1", 32'hDEAD_BEEF, 1'b0);
        applyStimulus(32'h89AB_CDEF, 5'd3, 2'b11, 1'b0); checkOutput("hold_2", 32'hDEAD_BEEF, 1'b0);

        // Asynchronous clear: assert reset between edges and check before the next posedge.
        applyStimulus(32'hA5A5_0F0F, 5'd1, 2'b11, 1'b1); checkOutput("pre_async", 32'hD2D2_8787, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_clear", 32'h0000_0000, 1'b0);
        #1 rst_n = 1'b1;

        $display("[TB] randomized run");
        exp_z = '0;
        exp_v = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 5'd0;
                1:       rb = 5'd31;
                default: rb = SHW'($urandom_range(0, WIDTH - 1));
            endcase
            rc = 2'($urandom_range(0, 3));
            rv = ($urandom_range(0, 3) != 0);
            if (i == 5000) begin
                @(negedge clk);
                in_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                checkOutput("rand_async_clear", 32'h0000_0000, 1'b0);
                #1 rst_n = 1'b1;
                exp_z = '0;
                exp_v = 1'b0;
            end
            applyStimulus(ra, rb, rc, rv);
            if (rv) begin
                exp_z = ref_shift(ra, rb, rc);
            end
            exp_v = rv;
            checkOutput("random", exp_z, exp_v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
